// File: rtl/mult_share_sched_pkg.sv
// Shared types and default constants for the shared-multiplier scheduler.
package mult_share_sched_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_ARM_CYC = 2;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester, response and multiplier-side signals of the scheduler.
// slave = scheduler side, master = environment (requesters, consumer, multiplier).
interface mult_share_sched_if
  import mult_share_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int OP_W  = DEF_OP_W
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]           REQ_VALID;
  logic [N_REQ-1:0][OP_W-1:0] REQ_A;
  logic [N_REQ-1:0][OP_W-1:0] REQ_B;
  logic [N_REQ-1:0]           REQ_READY;
  logic                       RSP_VALID;
  logic                       RSP_READY;
  logic [IDW-1:0]             RSP_ID;
  logic [2*OP_W-1:0]          RSP_P;
  logic                       RSP_ERR;
  logic                       MUL_START;
  logic [OP_W-1:0]            MUL_A;
  logic [OP_W-1:0]            MUL_B;
  logic                       MUL_READY;
  logic [2*OP_W-1:0]          MUL_P;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, RSP_READY, MUL_READY, MUL_P,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_P, RSP_ERR, MUL_START, MUL_A, MUL_B
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, RSP_READY, MUL_READY, MUL_P,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_P, RSP_ERR, MUL_START, MUL_A, MUL_B
  );

endinterface

// File: rtl/mult_share_sched_rr_arb.sv
// Round-robin arbiter: searches from the index after ptr, wrapping to 0,
// and returns a one-hot grant (all zero when nobody requests).
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;
  int   idx;

  // first requester at or after ptr+1 (mod N_REQ) wins
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Schedules N_REQ requesters onto one shared serial multiplier:
// grant -> start pulse -> arm (ready ignored) -> wait (with timeout) -> hold result.
module mult_share_sched
  import mult_share_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int OP_W    = DEF_OP_W,
  parameter int ARM_CYC = DEF_ARM_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic CK,
  input  logic RN,
  mult_share_sched_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT + ARM_CYC + 1) + 1;

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_ARM   = ST_ARM;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]        state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    id_q;
  logic [N_REQ-1:0]  gnt;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [2*OP_W-1:0] p_q;
  logic              err_q;
  logic [TW-1:0]     tmr;

  rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req (bus.REQ_VALID),
    .ptr (ptr),
    .gnt (gnt)
  );

  // one-hot grant to index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) gnt_idx = IDW'(i);
  end

  // REQ_READY is gated by RN so a request held during reset is never acknowledged
  assign bus.REQ_READY = (state == S_IDLE && RN) ? gnt : '0;
  assign bus.MUL_START = (state == S_START);
  assign bus.RSP_VALID = (state == S_DONE);
  assign bus.MUL_A     = a_q;
  assign bus.MUL_B     = b_q;
  assign bus.RSP_ID    = id_q;
  assign bus.RSP_P     = p_q;
  assign bus.RSP_ERR   = err_q;

  // scheduler FSM; tmr counts arm cycles, then wait cycles
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      ptr   <= IDW'(N_REQ - 1);
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
      tmr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            ptr   <= gnt_idx;
            id_q  <= gnt_idx;
            a_q   <= bus.REQ_A[gnt_idx];
            b_q   <= bus.REQ_B[gnt_idx];
            state <= S_START;
          end
        end
        S_START: begin
          tmr   <= '0;
          state <= (ARM_CYC == 0) ? S_WAIT : S_ARM;
        end
        S_ARM: begin
          if (tmr == TW'(ARM_CYC - 1)) begin
            tmr   <= '0;
            state <= S_WAIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.MUL_READY) begin
            p_q   <= bus.MUL_P;
            err_q <= 1'b0;
            tmr   <= '0;
            state <= S_DONE;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            p_q   <= '0;
            err_q <= 1'b1;
            tmr   <= '0;
            state <= S_DONE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.RSP_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a small serial-multiplier model.
module tb_mult_share_sched;
  localparam int N_REQ = 4;
  localparam int OP_W  = 4;
  localparam int ARM_CYC = 2;
  localparam int TIMEOUT = 16;

  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  mult_share_sched_if #(.N_REQ(N_REQ), .OP_W(OP_W)) bus ();

  mult_share_sched #(
    .N_REQ(N_REQ), .OP_W(OP_W), .ARM_CYC(ARM_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  // multiplier model: product ready mul_lat cycles after the start pulse
  int unsigned mul_lat  = 0;
  bit          mul_dead = 1'b0;
  int unsigned mcnt     = 0;
  logic        mbusy    = 1'b0;
  logic [7:0]  mprod    = '0;

  always @(posedge CK) begin
    if (bus.MUL_START) begin
      mbusy <= 1'b1;
      mcnt  <= mul_lat;
      mprod <= {4'b0, bus.MUL_A} * {4'b0, bus.MUL_B};
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign bus.MUL_READY = mbusy && (mcnt == 0) && !mul_dead;
  assign bus.MUL_P     = mprod;

  // grant / start monitor
  int cyc = 0;
  int n_start = 0;
  int g_idx[$];
  int g_cyc[$];

  always @(negedge CK) begin
    cyc++;
    #1;
    if (bus.MUL_START) n_start++;
    if (bus.REQ_READY != 0) begin
      for (int i = 0; i < N_REQ; i++)
        if (bus.REQ_READY[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
        end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one request/response transaction with hold cycles in DONE;
  // 'other' requesters are raised during the hold and dropped before ack
  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input int hold, input logic [3:0] other,
                       input logic [7:0] ep, input logic eerr, input int elat);
    int w;
    int lat;
    @(negedge CK);
    bus.REQ_A[id] = a;
    bus.REQ_B[id] = b;
    bus.REQ_VALID[id] = 1'b1;
    #1;
    w = 0;
    while (bus.REQ_READY == 0 && w < 50) begin
      @(negedge CK); #1; w++;
    end
    chk("grant", 32'(bus.REQ_READY), 32'(1) << id);
    n_start = 0;
    @(negedge CK); #1;
    bus.REQ_VALID[id] = 1'b0;
    lat = 1;
    chk("start_pulse", 32'(bus.MUL_START), 1);
    chk("mul_a", 32'(bus.MUL_A), 32'(a));
    chk("mul_b", 32'(bus.MUL_B), 32'(b));
    chk("no_grant_start", 32'(bus.REQ_READY), 0);
    while (!bus.RSP_VALID && lat < 60) begin
      @(negedge CK); #1; lat++;
      if (!bus.RSP_VALID) begin
        chk("mul_a_hold", 32'(bus.MUL_A), 32'(a));
        chk("mul_b_hold", 32'(bus.MUL_B), 32'(b));
      end
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("rsp_p", 32'(bus.RSP_P), 32'(ep));
    chk("rsp_id", 32'(bus.RSP_ID), 32'(id));
    chk("rsp_err", 32'(bus.RSP_ERR), 32'(eerr));
    chk("start_count", 32'(n_start), 1);
    bus.REQ_VALID = bus.REQ_VALID | other;
    for (int h = 0; h < hold; h++) begin
      @(negedge CK); #1;
      chk("hold_valid", 32'(bus.RSP_VALID), 1);
      chk("hold_p", 32'(bus.RSP_P), 32'(ep));
      chk("hold_id", 32'(bus.RSP_ID), 32'(id));
      chk("hold_no_grant", 32'(bus.REQ_READY), 0);
    end
    bus.REQ_VALID = bus.REQ_VALID & ~other;
    bus.RSP_READY = 1'b1;
    @(negedge CK); #1;
    bus.RSP_READY = 1'b0;
    chk("rsp_drop", 32'(bus.RSP_VALID), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.REQ_READY), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 0);
    chk({tag, "_rsp_p"},     32'(bus.RSP_P), 0);
    chk({tag, "_rsp_id"},    32'(bus.RSP_ID), 0);
    chk({tag, "_rsp_err"},   32'(bus.RSP_ERR), 0);
    chk({tag, "_mul_start"}, 32'(bus.MUL_START), 0);
    chk({tag, "_mul_a"},     32'(bus.MUL_A), 0);
    chk({tag, "_mul_b"},     32'(bus.MUL_B), 0);
  endtask

  initial begin
    int w;
    bus.REQ_VALID = '1;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b0;
    RN = 1'b0;

    // reset with requests pending: nothing acknowledged, all outputs zero
    repeat (2) @(negedge CK);
    #1;
    chk_zero_outputs("reset");
    bus.REQ_VALID = '0;
    @(negedge CK);
    RN = 1'b1;

    // basic products; ready arrives during arm and must be ignored
    mul_lat = 0;
    do_op(0, 4'd3, 4'd5, 0, 4'b0000, 8'd15, 1'b0, 5);
    do_op(1, 4'd15, 4'd15, 0, 4'b0000, 8'd225, 1'b0, 5);
    // consumer stalls 10 cycles; late requests are dropped before the return to idle
    do_op(2, 4'd7, 4'd9, 10, 4'b1011, 8'd63, 1'b0, 5);
    // slower multiplier: 4 wait cycles
    mul_lat = 5;
    do_op(3, 4'd6, 4'd7, 0, 4'b0000, 8'd42, 1'b0, 8);
    // no ready at all -> timeout
    mul_dead = 1'b1;
    do_op(0, 4'd9, 4'd9, 0, 4'b0000, 8'd0, 1'b1, 2 + ARM_CYC + TIMEOUT);

    // reset in the middle of WAIT
    @(negedge CK);
    bus.REQ_A[2] = 4'd5;
    bus.REQ_B[2] = 4'd6;
    bus.REQ_VALID[2] = 1'b1;
    #1;
    w = 0;
    while (bus.REQ_READY == 0 && w < 50) begin
      @(negedge CK); #1; w++;
    end
    chk("rst_mid_grant", 32'(bus.REQ_READY), 32'h4);
    @(negedge CK);
    bus.REQ_VALID = '0;
    repeat (4) @(negedge CK);
    RN = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    @(negedge CK);
    RN = 1'b1;
    mul_dead = 1'b0;
    mul_lat  = 0;
    bus.REQ_A[0] = 4'd2;
    bus.REQ_B[0] = 4'd3;
    bus.REQ_VALID = 4'b1011;
    #1;
    chk("rst_no_rsp", 32'(bus.RSP_VALID), 0);
    w = 0;
    while (bus.REQ_READY == 0 && w < 50) begin
      @(negedge CK); #1; w++;
    end
    chk("rst_next_grant", 32'(bus.REQ_READY), 32'h1);
    @(negedge CK);
    bus.REQ_VALID = '0;
    w = 0;
    #1;
    while (!bus.RSP_VALID && w < 60) begin
      @(negedge CK); #1; w++;
    end
    chk("rst_next_p", 32'(bus.RSP_P), 32'd6);
    chk("rst_next_id", 32'(bus.RSP_ID), 0);
    bus.RSP_READY = 1'b1;
    @(negedge CK);
    bus.RSP_READY = 1'b0;

    // all four requesting from reset: 0,1,2,3,0 spaced one full operation apart
    @(negedge CK);
    RN = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.REQ_A[i] = 4'(i + 1);
      bus.REQ_B[i] = 4'd2;
    end
    bus.REQ_VALID = '1;
    bus.RSP_READY = 1'b1;
    repeat (2) @(negedge CK);
    g_idx.delete();
    g_cyc.delete();
    RN = 1'b1;
    w = 0;
    while (g_idx.size() < 5 && w < 60) begin
      @(negedge CK); w++;
    end
    #2;
    chk("rr_count", 32'(g_idx.size() >= 5), 1);
    if (g_idx.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        chk($sformatf("rr_order%0d", k), 32'(g_idx[k]), 32'(k % N_REQ));
      for (int k = 1; k < 5; k++)
        chk($sformatf("rr_gap%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'(3 + ARM_CYC + 1));
    end
    bus.REQ_VALID = '0;
    repeat (12) @(negedge CK);
    bus.RSP_READY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
MULT_SHARE_SCHED -- requirements
Module: mult_share_sched

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter OP_W, default 4, operand width; product width is 2*OP_W.
REQ-003 SHALL provide parameter ARM_CYC, default 2, cycles during which MUL_READY is ignored after MUL_START.
REQ-004 SHALL provide parameter TIMEOUT, default 16, maximum cycles to wait for MUL_READY.
REQ-005 SHALL have port CK, in, 1, rising-edge clock.
REQ-006 SHALL have port RN, in, 1, reset. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have port REQ_VALID, in, N_REQ, per-requester request.
REQ-008 SHALL have port REQ_A, in, N_REQ*OP_W, packed multiplicands; requester i occupies slice i.
REQ-009 SHALL have port REQ_B, in, N_REQ*OP_W, packed multipliers.
REQ-010 SHALL have port REQ_READY, out, N_REQ, one-hot accept pulse.
REQ-011 SHALL have port RSP_VALID, out, 1, result available.
REQ-012 SHALL have port RSP_READY, in, 1, result consumed.
REQ-013 SHALL have port RSP_ID, out, clog2(N_REQ), index of the served requester.
REQ-014 SHALL have port RSP_P, out, 2*OP_W, product.
REQ-015 SHALL have port RSP_ERR, out, 1, timeout flag.
REQ-016 SHALL have ports MUL_START (out, 1), MUL_A (out, OP_W) and MUL_B (out, OP_W), driving the shared serial multiplier.
REQ-017 SHALL have ports MUL_READY (in, 1) and MUL_P (in, 2*OP_W), returned by the shared serial multiplier.

Function
REQ-018 FSM SHALL have states IDLE, START, ARM, WAIT, DONE.
REQ-019 IDLE: when any REQ_VALID=1, SHALL grant one requester round-robin, beginning at the index after the last granted; SHALL pulse the matching REQ_READY bit for exactly that cycle, latch the operands and ID, and go to START.
REQ-020 START: SHALL assert MUL_START for exactly one cycle, then go to ARM.
REQ-021 ARM: SHALL ignore MUL_READY for ARM_CYC cycles, then go to WAIT.
REQ-022 WAIT: on MUL_READY=1, SHALL capture MUL_P into RSP_P, clear RSP_ERR and go to DONE.
REQ-023 WAIT: if TIMEOUT cycles elapse with MUL_READY=0, SHALL set RSP_P=0 and RSP_ERR=1 and go to DONE.
REQ-024 DONE: SHALL hold RSP_VALID=1 with RSP_P, RSP_ID and RSP_ERR stable until RSP_READY=1; that cycle SHALL return to IDLE.
REQ-025 MUL_A and MUL_B SHALL hold the latched operands, unchanged, from START through the end of WAIT.
REQ-026 No new grant SHALL occur outside IDLE; REQ_READY SHALL be 0 in every other state.
REQ-027 A REQ_VALID deasserted before its grant SHALL be dropped without effect.
REQ-028 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-029 Grant-to-RSP_VALID latency SHALL be 2+ARM_CYC+k cycles, where k is the number of WAIT cycles.
REQ-030 MUL_READY already high on WAIT entry SHALL complete in the first WAIT cycle.

Reset
REQ-031 While RN=0, state SHALL be IDLE and the pointer SHALL be N_REQ-1, so that requester 0 has first priority.
REQ-032 While RN=0, all outputs SHALL be 0 and the latched operands and timer SHALL be cleared.
REQ-033 Reset mid-operation SHALL abandon the operation with no response, and MUL_START SHALL deassert immediately.

Structure
REQ-034 A shared package SHALL hold the state enum and the default constants for OP_W, ARM_CYC and TIMEOUT.
REQ-035 The round-robin grant logic SHALL be one sub-module, rr_arb (request vector and pointer in, one-hot grant out).

Verification
REQ-036 Scenario: after reset, requester 0 requests A=3, B=5 -> REQ_READY=0001, one MUL_START pulse, then RSP_P=15, RSP_ID=0, RSP_ERR=0.
REQ-037 Scenario: A=15, B=15 -> RSP_P=225.
REQ-038 Scenario: all four REQ_VALID held high from reset -> grants in order 0,1,2,3,0, with no back-to-back grant inside one operation.
REQ-039 Scenario: RSP_READY held low for 10 cycles in DONE -> RSP_VALID, RSP_P and RSP_ID stay stable and no new grant occurs.
REQ-040 Scenario: model holds MUL_READY=0 -> after TIMEOUT=16 WAIT cycles, RSP_ERR=1 and RSP_P=0.
REQ-041 Scenario: RN pulsed low during WAIT -> all outputs 0 and next grant goes to requester 0.
